alu_regfile_pipe: RTL and testbench
===================================

Name: alu_regfile_pipe

Overview:
- Parametrised next generation of alu_registers: a NUM_REGS x DATA_WIDTH register file fused with a two-stage ALU pipeline.
- Adds a valid/ready issue handshake, operand forwarding, a status flag register, an extended opcode set and an optional iterative multiplier.
- Sits between instruction decode (issue side) and the processor datapath (result side).

Parameters:
DATA_WIDTH, 8, register and operand width in bits
NUM_REGS, 8, number of registers (power of two, >= 2)
ADDR_WIDTH, $clog2(NUM_REGS), register address width

Ports:
clk  input  1  clock; all state changes on posedge
reset  input  1  synchronous, active-low reset (sampled on posedge clk; 0 = reset)
in_valid  input  1  issue request
in_ready  output  1  block can accept an op this cycle
op  input  ALUOp  operation (constants_pkg)
addr_a  input  ADDR_WIDTH  operand A / REG_READ / REG_WRITE address
addr_b  input  ADDR_WIDTH  operand B address
addr_r  input  ADDR_WIDTH  ALU result address
data_in  input  DATA_WIDTH  REG_WRITE data
data_out  output  DATA_WIDTH  value of last completed op
out_valid  output  1  one-cycle pulse per completed op
flags  output  3  {neg, carry, zero}
err  output  1  one-cycle pulse: illegal op retired

Behaviour:
- Reset (reset==0 at posedge): all registers, flags, data_out, out_valid, err, pipeline and FSM cleared; in_ready=0 while reset is low. An in-flight MUL is abandoned with no write.
- Accept on posedge when in_valid && in_ready. Edge N: S1 latches op, addresses, data_in and operands A/B. Edge N+1: execute, register write-back, flags update, data_out update, out_valid=1. Latency = 2 edges; throughput = 1 op/cycle.
- Forwarding: an operand read at edge N+1 whose address matches the register being written at that edge gets the new value. ADDC also uses the carry being produced at the same edge. Back-to-back dependent ops never stall.
- REG_WRITE: reg[addr_a]=data_in; data_out=data_in; flags unchanged.
- REG_READ: data_out=reg[addr_a]; no register write; flags unchanged.
- ADD/ADDC/SUB/AND/OR/XOR/SHL/SHR: reg[addr_r]=f(reg[addr_a],reg[addr_b]); data_out=result.
  - ADD/ADDC: carry = bit DATA_WIDTH of the sum.
  - SUB: carry = borrow (A<B unsigned).
  - SHL/SHR: shift A by 1; carry = bit shifted out; B ignored.
  - Logic ops: carry cleared.
  - All ALU ops: zero = (result==0); neg = result MSB.
- addr_r equal to addr_a or addr_b: the operands are the pre-write values.
- FSM states: RUN (in_ready=1), MUL_BUSY (in_ready=0, S1 held, input ignored).
- Illegal op (undefined encoding, or MUL without the macro): no register or flag change; data_out held; err=1 and out_valid=0 at the write-back edge.
- Outputs are registered; out_valid and err are low in every cycle without a retirement.

Optional Feature:
- Macro ALU_MUL_EN.
- Defined: MUL is an iterative shift-add.
  - RUN -> MUL_BUSY when MUL enters S1; stays DATA_WIDTH cycles, then writes reg[addr_r] = low DATA_WIDTH bits of the product and returns to RUN.
  - Flags: carry = (high half != 0); zero and neg from the low half.
  - Total MUL latency = DATA_WIDTH+1 edges; forwarding applies at retirement.
- Undefined: no multiplier logic and no MUL_BUSY state; MUL is illegal (err pulse).

Decomposition:
- constants_pkg:
  - Extend ALUOp with ADDC, SUB, AND, OR, XOR, SHL, SHR, MUL (existing encodings of REG_READ, REG_WRITE, ADD unchanged).
  - Add enum alu_pipe_state_t {RUN, MUL_BUSY}.
  - Add flag bit-index constants FLAG_ZERO=0, FLAG_CARRY=1, FLAG_NEG=2.
- Sub-module alu_seq_multiplier (start, a, b -> done, product[2*DATA_WIDTH-1:0]), instantiated only under ALU_MUL_EN.

Test Plan:
- Reset low 2 cycles, then REG_READ r0..r7 -> data_out=0x00 on each out_valid pulse, flags=3'b000, in_ready=1 after reset release.
- Back-to-back, no idle: WRITE r0=0x42, WRITE r1=0x24, ADD r2=r0+r1 -> forwarding gives r2=0x66; READ r0/r1/r2 -> 0x42/0x24/0x66; flags=000.
- Fibonacci with consecutive issue: r0=0, r1=1, r2=1; ADD r3..r7 from the previous two registers -> r3..r7 = 0x02,0x03,0x05,0x08,0x0d; no stall (in_ready stays 1).
- Carry chain: r0=0xFF, r1=0x01; ADD r2=r0+r1 -> 0x00, zero=1, carry=1; immediately ADDC r3=r0+r0 -> 0xFF, carry=1, neg=1. Then SUB r4=0x10-0x20 -> 0xF0, carry=1, neg=1.
- ALU_MUL_EN defined: MUL 0x0F*0x11 -> 0xFF, carry=0; in_ready low exactly 8 cycles; MUL 0x10*0x10 -> 0x00, zero=1, carry=1; reset asserted mid-MUL -> destination register stays 0x00.
- ALU_MUL_EN undefined: MUL r2=r0*r1 -> err pulse for 1 cycle, out_valid=0, r2 and flags unchanged; next op is accepted the following cycle.

Source files
------------

// File: rtl/constants_pkg.sv
// constants_pkg: shared types and constants for alu_regfile_pipe.
//   ALUOp            - issue-side operation encoding (4 bits; 11..15 are illegal)
//   alu_pipe_state_t - issue FSM state (MUL_BUSY exists only when ALU_MUL_EN is defined)
//   FLAG_*           - bit positions inside the {neg, carry, zero} flag register
package constants_pkg;

    typedef enum logic [3:0] {
        REG_READ  = 4'd0,
        REG_WRITE = 4'd1,
        ADD       = 4'd2,
        ADDC      = 4'd3,
        SUB       = 4'd4,
        AND       = 4'd5,
        OR        = 4'd6,
        XOR       = 4'd7,
        SHL       = 4'd8,
        SHR       = 4'd9,
        MUL       = 4'd10
    } ALUOp;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MUL_BUSY = 1'b1
    } alu_pipe_state_t;

    localparam int unsigned FLAG_ZERO  = 0;
    localparam int unsigned FLAG_CARRY = 1;
    localparam int unsigned FLAG_NEG   = 2;
    localparam int unsigned FLAG_WIDTH = 3;

endpackage

// File: rtl/alu_seq_multiplier.sv
// alu_seq_multiplier: iterative shift-add unsigned multiplier, one partial product per cycle.
// Ports:
//   clk, reset (sync, active-low) - clock / reset; reset abandons any product in progress
//   start                         - load a/b and begin; takes DATA_WIDTH further edges
//   a, b                          - operands (sampled on the start edge)
//   done                          - high in the cycle before the final step edge
//   product                       - full 2*DATA_WIDTH product, valid while done is high
module alu_seq_multiplier #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [DATA_WIDTH-1:0]   a,
    input  logic [DATA_WIDTH-1:0]   b,
    output logic                    done,
    output logic [2*DATA_WIDTH-1:0] product
);

    localparam int unsigned CntWidth = $clog2(DATA_WIDTH + 1);

    logic [2*DATA_WIDTH-1:0] mcand_q;
    logic [2*DATA_WIDTH-1:0] acc_q;
    logic [DATA_WIDTH-1:0]   mplier_q;
    logic [CntWidth-1:0]     cnt_q;
    logic [2*DATA_WIDTH-1:0] step_acc;

    // The product is exposed as the accumulator *after* the pending step, so the
    // owner can retire on the same edge that performs the last step.
    always_comb begin
        step_acc = acc_q + (mplier_q[0] ? mcand_q : '0);
        product  = step_acc;
        done     = (cnt_q == CntWidth'(1));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else if (start) begin
            mcand_q  <= {{DATA_WIDTH{1'b0}}, a};
            acc_q    <= '0;
            mplier_q <= b;
            cnt_q    <= CntWidth'(DATA_WIDTH);
        end else if (cnt_q != '0) begin
            acc_q    <= step_acc;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - CntWidth'(1);
        end
    end

endmodule

// File: rtl/alu_regfile_pipe.sv
// alu_regfile_pipe: NUM_REGS x DATA_WIDTH register file fused with a two-stage ALU pipeline.
// Stage S1 captures the op and its (forwarded) operands on the accept edge; the next edge
// executes, writes back, updates flags/data_out and pulses out_valid (or err if illegal).
// Ports:
//   clk, reset (sync, active-low)   - clock / reset
//   in_valid, in_ready              - issue handshake
//   op, addr_a, addr_b, addr_r      - operation and register addresses
//   data_in                         - REG_WRITE data
//   data_out, out_valid             - result of last completed op, one-cycle retire pulse
//   flags                           - {neg, carry, zero}
//   err                             - one-cycle pulse when an illegal op retires
// Build option: define ALU_MUL_EN to add the iterative MUL (otherwise MUL is illegal).
module alu_regfile_pipe
    import constants_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_REGS   = 8,
    parameter int unsigned ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  ALUOp                  op,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [ADDR_WIDTH-1:0] addr_r,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  out_valid,
    output logic [FLAG_WIDTH-1:0] flags,
    output logic                  err
);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

    logic                  s1_valid_q;
    ALUOp                  s1_op_q;
    logic [ADDR_WIDTH-1:0] s1_addr_a_q;
    logic [ADDR_WIDTH-1:0] s1_addr_r_q;
    logic [DATA_WIDTH-1:0] s1_data_q;
    logic [DATA_WIDTH-1:0] s1_a_q;
    logic [DATA_WIDTH-1:0] s1_b_q;

    logic [DATA_WIDTH-1:0] data_out_q;
    logic                  out_valid_q;
    logic                  err_q;
    logic [FLAG_WIDTH-1:0] flags_q;

    logic                  accept;
    logic                  retire;
    logic                  illegal;
    logic                  wb_we;
    logic                  wb_en;
    logic [ADDR_WIDTH-1:0] wb_addr;
    logic [DATA_WIDTH-1:0] res_data;
    logic [FLAG_WIDTH-1:0] flags_new;
    logic                  alu_op;
    logic [DATA_WIDTH-1:0] alu_res;
    logic                  alu_carry;
    logic [DATA_WIDTH:0]   ext;
    logic [DATA_WIDTH-1:0] fwd_a;
    logic [DATA_WIDTH-1:0] fwd_b;

`ifdef ALU_MUL_EN
    alu_pipe_state_t         state_q;
    alu_pipe_state_t         state_d;
    logic                    mul_done;
    logic [2*DATA_WIDTH-1:0] mul_product;

    alu_seq_multiplier #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (accept && (op == MUL)),
        .a       (fwd_a),
        .b       (fwd_b),
        .done    (mul_done),
        .product (mul_product)
    );

    // Issue FSM: state register / next state / outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:      if (accept && (op == MUL)) state_d = MUL_BUSY;
            MUL_BUSY: if (mul_done) state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    always_comb begin
        in_ready = reset && (state_q == RUN);
    end

    // A MUL in S1 only completes when the multiplier finishes its last step.
    always_comb begin
        retire = s1_valid_q && ((s1_op_q == MUL) ? mul_done : 1'b1);
    end
`else
    always_comb begin
        in_ready = reset;
        retire   = s1_valid_q;
    end
`endif

    always_comb begin
        accept = in_valid && in_ready;
    end

    // Execute stage for the op held in S1.
    always_comb begin
        wb_we     = 1'b0;
        wb_addr   = s1_addr_r_q;
        res_data  = data_out_q;
        flags_new = flags_q;
        illegal   = 1'b0;
        alu_op    = 1'b0;
        alu_res   = '0;
        alu_carry = 1'b0;
        ext       = '0;
        case (s1_op_q)
            REG_WRITE: begin
                wb_we    = 1'b1;
                wb_addr  = s1_addr_a_q;
                res_data = s1_data_q;
            end
            REG_READ: res_data = s1_a_q;
            ADD: begin
                alu_op    = 1'b1;
                ext       = {1'b0, s1_a_q} + {1'b0, s1_b_q};
                alu_res   = ext[DATA_WIDTH-1:0];
                alu_carry = ext[DATA_WIDTH];
            end
            ADDC: begin
                // flags_q already holds the carry of the op retired on the previous edge.
                alu_op    = 1'b1;
                ext       = {1'b0, s1_a_q} + {1'b0, s1_b_q}
                            + {{DATA_WIDTH{1'b0}}, flags_q[FLAG_CARRY]};
                alu_res   = ext[DATA_WIDTH-1:0];
                alu_carry = ext[DATA_WIDTH];
            end
            SUB: begin
                // Bit DATA_WIDTH of the extended difference is the unsigned borrow.
                alu_op    = 1'b1;
                ext       = {1'b0, s1_a_q} - {1'b0, s1_b_q};
                alu_res   = ext[DATA_WIDTH-1:0];
                alu_carry = ext[DATA_WIDTH];
            end
            AND: begin
                alu_op  = 1'b1;
                alu_res = s1_a_q & s1_b_q;
            end
            OR: begin
                alu_op  = 1'b1;
                alu_res = s1_a_q | s1_b_q;
            end
            XOR: begin
                alu_op  = 1'b1;
                alu_res = s1_a_q ^ s1_b_q;
            end
            SHL: begin
                alu_op    = 1'b1;
                alu_res   = s1_a_q << 1;
                alu_carry = s1_a_q[DATA_WIDTH-1];
            end
            SHR: begin
                alu_op    = 1'b1;
                alu_res   = s1_a_q >> 1;
                alu_carry = s1_a_q[0];
            end
`ifdef ALU_MUL_EN
            MUL: begin
                alu_op    = 1'b1;
                alu_res   = mul_product[DATA_WIDTH-1:0];
                alu_carry = |mul_product[2*DATA_WIDTH-1:DATA_WIDTH];
            end
`endif
            default: illegal = 1'b1;
        endcase
        if (alu_op) begin
            wb_we                 = 1'b1;
            res_data              = alu_res;
            flags_new[FLAG_ZERO]  = (alu_res == '0);
            flags_new[FLAG_CARRY] = alu_carry;
            flags_new[FLAG_NEG]   = alu_res[DATA_WIDTH-1];
        end
    end

    // Operands captured on the accept edge see the value written back on that same edge.
    always_comb begin
        wb_en = retire && wb_we;
        fwd_a = (wb_en && (wb_addr == addr_a)) ? res_data : regs_q[addr_a];
        fwd_b = (wb_en && (wb_addr == addr_b)) ? res_data : regs_q[addr_b];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
            s1_valid_q  <= 1'b0;
            s1_op_q     <= REG_READ;
            s1_addr_a_q <= '0;
            s1_addr_r_q <= '0;
            s1_data_q   <= '0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            flags_q     <= '0;
        end else begin
            out_valid_q <= retire && !illegal;
            err_q       <= retire && illegal;
            if (retire && !illegal) begin
                data_out_q <= res_data;
                flags_q    <= flags_new;
            end
            if (wb_en) begin
                regs_q[wb_addr] <= res_data;
            end
            if (accept) begin
                s1_valid_q  <= 1'b1;
                s1_op_q     <= op;
                s1_addr_a_q <= addr_a;
                s1_addr_r_q <= addr_r;
                s1_data_q   <= data_in;
                s1_a_q      <= fwd_a;
                s1_b_q      <= fwd_b;
            end else if (retire) begin
                s1_valid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        data_out  = data_out_q;
        out_valid = out_valid_q;
        err       = err_q;
        flags     = flags_q;
    end

endmodule

// File: tb/tb_alu_regfile_pipe.sv
// Scoreboard bench for alu_regfile_pipe (DATA_WIDTH=8, NUM_REGS=8). Expected retirements are
// queued at issue time and checked by an independent monitor on each out_valid/err pulse.
// Covers both builds: with and without ALU_MUL_EN.
module tb_alu_regfile_pipe;
    import constants_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    ALUOp       op = REG_READ;
    logic [2:0] addr_a = '0;
    logic [2:0] addr_b = '0;
    logic [2:0] addr_r = '0;
    logic [7:0] data_in = '0;
    logic [7:0] data_out;
    logic       out_valid;
    logic [2:0] flags;
    logic       err;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        logic [2:0] flg;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   stall_cnt = 0;

    alu_regfile_pipe #(
        .DATA_WIDTH (8),
        .NUM_REGS   (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .addr_a    (addr_a),
        .addr_b    (addr_b),
        .addr_r    (addr_r),
        .data_in   (data_in),
        .data_out  (data_out),
        .out_valid (out_valid),
        .flags     (flags),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every retirement pulse pops one expectation.
    always @(negedge clk) begin
        if (reset && (out_valid || err)) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_retire: out_valid=%0b err=%0b, expected no pulse",
                         out_valid, err);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("retire_kind", {30'd0, out_valid, err}, e.is_err ? 32'd1 : 32'd2);
                check("data_out", {24'd0, data_out}, {24'd0, e.data});
                check("flags", {29'd0, flags}, {29'd0, e.flg});
            end
        end
    end

    // Drive one op at #1 after an edge, wait (bounded) for in_ready, hold for the accept edge.
    task automatic issue(input ALUOp o, input int a, input int b, input int r, input int d,
                         input bit e_err, input int e_data, input int e_flags,
                         input bit push = 1'b1);
        int w = 0;
        exp_t e;
        in_valid = 1'b1;
        op       = o;
        addr_a   = 3'(a);
        addr_b   = 3'(b);
        addr_r   = 3'(r);
        data_in  = 8'(d);
        while (!in_ready && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        stall_cnt += w;
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_timeout: in_ready=0, expected 1");
            in_valid = 1'b0;
            return;
        end
        if (push) begin
            e.is_err = e_err;
            e.data   = 8'(e_data);
            e.flg    = 3'(e_flags);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        int s0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", {31'd0, in_ready}, 32'd0);
        check("reset_data_out", {24'd0, data_out}, 32'd0);
        check("reset_flags", {29'd0, flags}, 32'd0);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        reset = 1'b1;
        #1;
        check("ready_after_reset", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 8; i++) issue(REG_READ, i, 0, 0, 0, 0, 8'h00, 3'b000);

        // Back-to-back writes then a dependent add (forwarding).
        issue(REG_WRITE, 0, 0, 0, 8'h42, 0, 8'h42, 3'b000);
        issue(REG_WRITE, 1, 0, 0, 8'h24, 0, 8'h24, 3'b000);
        issue(ADD,       0, 1, 2, 0,     0, 8'h66, 3'b000);
        issue(REG_READ,  0, 0, 0, 0,     0, 8'h42, 3'b000);
        issue(REG_READ,  1, 0, 0, 0,     0, 8'h24, 3'b000);
        issue(REG_READ,  2, 0, 0, 0,     0, 8'h66, 3'b000);

        // Fibonacci chain with no stall.
        s0 = stall_cnt;
        issue(REG_WRITE, 0, 0, 0, 8'h00, 0, 8'h00, 3'b000);
        issue(REG_WRITE, 1, 0, 0, 8'h01, 0, 8'h01, 3'b000);
        issue(REG_WRITE, 2, 0, 0, 8'h01, 0, 8'h01, 3'b000);
        issue(ADD, 1, 2, 3, 0, 0, 8'h02, 3'b000);
        issue(ADD, 2, 3, 4, 0, 0, 8'h03, 3'b000);
        issue(ADD, 3, 4, 5, 0, 0, 8'h05, 3'b000);
        issue(ADD, 4, 5, 6, 0, 0, 8'h08, 3'b000);
        issue(ADD, 5, 6, 7, 0, 0, 8'h0d, 3'b000);
        check("fib_no_stall", 32'(stall_cnt - s0), 32'd0);

        // Carry chain, subtract with borrow, logic ops and shifts.
        issue(REG_WRITE, 0, 0, 0, 8'hFF, 0, 8'hFF, 3'b000);
        issue(REG_WRITE, 1, 0, 0, 8'h01, 0, 8'h01, 3'b000);
        issue(ADD,  0, 1, 2, 0, 0, 8'h00, 3'b011);
        issue(ADDC, 0, 0, 3, 0, 0, 8'hFF, 3'b110);
        issue(REG_WRITE, 5, 0, 0, 8'h10, 0, 8'h10, 3'b110);
        issue(REG_WRITE, 6, 0, 0, 8'h20, 0, 8'h20, 3'b110);
        issue(SUB, 5, 6, 4, 0, 0, 8'hF0, 3'b110);
        issue(AND, 0, 1, 7, 0, 0, 8'h01, 3'b000);
        issue(XOR, 0, 0, 7, 0, 0, 8'h00, 3'b001);
        issue(SHL, 0, 7, 2, 0, 0, 8'hFE, 3'b110);
        issue(SHR, 1, 7, 1, 0, 0, 8'h00, 3'b011);
        issue(OR,  5, 6, 3, 0, 0, 8'h30, 3'b000);
        issue(ADD, 5, 5, 5, 0, 0, 8'h20, 3'b000);
        issue(ADD, 5, 5, 5, 0, 0, 8'h40, 3'b000);
        issue(REG_READ, 5, 0, 0, 0, 0, 8'h40, 3'b000);
        issue(REG_READ, 4, 0, 0, 0, 0, 8'hF0, 3'b000);
        issue(SHL, 0, 0, 2, 0, 0, 8'hFE, 3'b110);

`ifdef ALU_MUL_EN
        begin
            int low = 0;
            issue(REG_WRITE, 0, 0, 0, 8'h0F, 0, 8'h0F, 3'b110);
            issue(REG_WRITE, 1, 0, 0, 8'h11, 0, 8'h11, 3'b110);
            issue(MUL, 0, 1, 2, 0, 0, 8'hFF, 3'b100);
            while (!in_ready && low < 40) begin
                @(posedge clk);
                #1;
                low++;
            end
            check("mul_busy_cycles", 32'(low), 32'd8);
            issue(REG_WRITE, 3, 0, 0, 8'h10, 0, 8'h10, 3'b100);
            issue(MUL, 3, 3, 4, 0, 0, 8'h00, 3'b011);
            issue(ALUOp'(4'd12), 0, 0, 0, 0, 1, 8'h00, 3'b011);
            // Reset in the middle of a MUL: result must never land.
            issue(MUL, 0, 1, 5, 0, 0, 0, 0, 1'b0);
            repeat (3) @(posedge clk);
            #1;
            reset = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            reset = 1'b1;
            issue(REG_READ, 5, 0, 0, 0, 0, 8'h00, 3'b000);
        end
`else
        s0 = stall_cnt;
        issue(MUL, 0, 1, 2, 0, 1, 8'hFE, 3'b110);
        issue(ALUOp'(4'd12), 0, 0, 0, 0, 1, 8'hFE, 3'b110);
        issue(REG_READ, 2, 0, 0, 0, 0, 8'hFE, 3'b110);
        check("illegal_no_stall", 32'(stall_cnt - s0), 32'd0);
`endif

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
